// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmit path.
package uart_pkg;

  localparam int UART_FRAME_BITS           = 10;
  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered pointers and level; flags derive from the level.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                          BCLK,
  input  logic                          RST,
  input  logic [UART_DATA_BITS-1:0]     wr_data,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic [UART_DATA_BITS-1:0]     rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic                      push;
  logic                      pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge BCLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge BCLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_controller.sv
// Pulls bytes from the FIFO and sequences one load plus ten baud-spaced shift
// pulses per 8N1 frame into the downstream shift register.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          BCLK,
  input  logic                          RST,
  input  logic [UART_DATA_BITS-1:0]     s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [UART_DATA_BITS-1:0]     tx_data,
  output logic                          signal_load,
  output logic                          signal_shift,
  input  logic                          signal_busy,
  output logic                          tx_idle,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    SHIFT_LAST = 4'(UART_FRAME_BITS);

  tx_state_t                 state;
  logic [BW-1:0]             baud_cnt;
  logic [3:0]                shift_cnt;
  logic [UART_DATA_BITS-1:0] head;
  logic                      full;
  logic                      empty;
  logic                      pop;

  assign pop     = (state == IDLE) && !empty;
  assign s_ready = !full;
  assign tx_idle = empty && (state == IDLE);

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .BCLK    (BCLK),
    .RST     (RST),
    .wr_data (s_data),
    .wr_en   (s_valid),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // The baud counter already advances in LOAD so the first shift lands exactly
  // CLKS_PER_BIT cycles after the load edge.
  always_ff @(posedge BCLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      tx_data      <= '0;
      signal_load  <= 1'b0;
      signal_shift <= 1'b0;
      baud_cnt     <= '0;
      shift_cnt    <= '0;
      frame_err    <= 1'b0;
    end else begin
      signal_load  <= 1'b0;
      signal_shift <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            tx_data     <= head;
            signal_load <= 1'b1;
            baud_cnt    <= '0;
            shift_cnt   <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          baud_cnt <= baud_cnt + 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (shift_cnt == SHIFT_LAST) begin
            state <= IDLE;
          end else if (!signal_busy && shift_cnt != 4'd0) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (baud_cnt == BAUD_LAST) begin
            signal_shift <= 1'b1;
            shift_cnt    <= shift_cnt + 4'd1;
            baud_cnt     <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller with a behavioural shift register attached.
module tb_uart_tx_controller;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       BCLK = 1'b0;
  logic       RST;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] tx_data;
  logic       signal_load;
  logic       signal_shift;
  logic       signal_busy;
  logic       tx_idle;
  logic [2:0] fifo_level;
  logic       frame_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [9:0] sr;
  logic       line;
  logic       sr_busy;
  int         sr_cnt;
  logic       kill;

  logic bits[$];
  int   shift_cyc[$];
  int   load_cyc[$];
  logic [7:0] load_data[$];
  int   overlap = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;
  } vec_t;

  vec_t vecs[3];

  uart_tx_controller #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .BCLK         (BCLK),
    .RST          (RST),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .tx_data      (tx_data),
    .signal_load  (signal_load),
    .signal_shift (signal_shift),
    .signal_busy  (signal_busy),
    .tx_idle      (tx_idle),
    .fifo_level   (fifo_level),
    .frame_err    (frame_err)
  );

  always #5 BCLK = ~BCLK;

  always @(posedge BCLK) cyc <= cyc + 1;

  // Stand-in for the real shift register: start bit, data LSB first, stop bit.
  always @(posedge BCLK or posedge RST) begin
    if (RST) begin
      sr <= 10'h3FF; line <= 1'b1; sr_busy <= 1'b0; sr_cnt <= 0;
    end else if (signal_load) begin
      sr <= {1'b1, tx_data, 1'b0}; sr_busy <= 1'b1; sr_cnt <= 0;
    end else if (signal_shift) begin
      line <= sr[0];
      sr <= {1'b1, sr[9:1]};
      sr_cnt <= sr_cnt + 1;
      if (sr_cnt == 9) sr_busy <= 1'b0;
    end
  end

  assign signal_busy = sr_busy && !kill;

  always @(negedge BCLK) begin
    if (!RST) begin
      if (signal_shift) begin
        bits.push_back(sr[0]);
        shift_cyc.push_back(cyc);
      end
      if (signal_load) begin
        load_data.push_back(tx_data);
        load_cyc.push_back(cyc);
      end
      if (signal_load && signal_shift) overlap = overlap + 1;
    end
  end

  task automatic step();
    @(negedge BCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    step();
    s_data = d;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic clearLog();
    bits.delete(); shift_cyc.delete(); load_cyc.delete(); load_data.delete();
  endtask

  task automatic waitShifts(input string name, input int target, input int budget);
    for (int i = 0; i < budget && bits.size() < target; i++) step();
    checkOutput(name, bits.size(), target);
  endtask

  function automatic logic [7:0] frameByte(input int f);
    logic [7:0] b = '0;
    for (int j = 0; j < 8; j++)
      if (f*10 + 1 + j < bits.size()) b[j] = bits[f*10 + 1 + j];
    return b;
  endfunction

  initial begin
    logic [7:0] burst[5];
    logic [9:0] got;
    int bad;
    int line_low;
    int i;
    int guard;
    logic ready_before;
    logic saw_full;
    int ready_bad;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h3C, 10'b1001111000};
    vecs[2] = '{8'h01, 10'b1000000010};
    burst = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h81};

    RST = 1'b1; s_valid = 1'b0; s_data = '0; kill = 1'b0;
    repeat (3) step();
    RST = 1'b0;
    step();

    checkOutput("rst_tx_idle", tx_idle, 1);
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_load", signal_load, 0);
    checkOutput("rst_shift", signal_shift, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    line_low = 0;
    repeat (100) begin
      step();
      if (line !== 1'b1) line_low++;
    end
    checkOutput("idle_pulses", bits.size() + load_cyc.size(), 0);
    checkOutput("idle_line_low", line_low, 0);

    for (int v = 0; v < 3; v++) begin
      clearLog();
      applyStimulus(vecs[v].data);
      waitShifts($sformatf("vec%0d_timeout", v), 10, 100);
      repeat (3) step();
      got = '0;
      for (int k = 0; k < 10 && k < bits.size(); k++) got[k] = bits[k];
      bad = 0;
      for (int k = 0; k < shift_cyc.size() && load_cyc.size() > 0; k++)
        if (shift_cyc[k] - load_cyc[0] != CPB*(k+1)) bad++;
      checkOutput($sformatf("vec%0d_bits", v), got, vecs[v].seq);
      checkOutput($sformatf("vec%0d_loads", v), load_cyc.size(), 1);
      checkOutput($sformatf("vec%0d_spacing", v), bad, 0);
      checkOutput($sformatf("vec%0d_tx_idle", v), tx_idle, 1);
    end

    // Burst with s_valid held high until every byte is accepted.
    clearLog();
    step();
    i = 0; guard = 0; saw_full = 1'b0; ready_bad = 0;
    s_data = burst[0]; s_valid = 1'b1;
    while (i < 5 && guard < 500) begin
      ready_before = s_ready;
      step();
      guard++;
      if (fifo_level == 3'd4) saw_full = 1'b1;
      if (fifo_level == 3'd4 && s_ready) ready_bad++;
      if (ready_before) begin
        i++;
        if (i < 5) s_data = burst[i];
        else s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    checkOutput("burst_accepted", i, 5);
    checkOutput("burst_saw_full", saw_full, 1);
    checkOutput("burst_ready_when_full", ready_bad, 0);
    waitShifts("burst_timeout", 50, 800);
    checkOutput("burst_loads", load_cyc.size(), 5);
    for (int f = 0; f < 5; f++) begin
      checkOutput($sformatf("burst_byte%0d", f), frameByte(f), burst[f]);
      if (f < load_data.size())
        checkOutput($sformatf("burst_load%0d", f), load_data[f], burst[f]);
    end
    bad = 0;
    for (int f = 1; f < load_cyc.size(); f++)
      if (load_cyc[f] - load_cyc[f-1] != 42) bad++;
    checkOutput("burst_period", bad, 0);
    checkOutput("overlap", overlap, 0);

    // Push on the very edge the FSM pops, with two bytes buffered.
    repeat (5) step();
    clearLog();
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    waitShifts("pp_timeout", 10, 100);
    checkOutput("pp_level_before", fifo_level, 2);
    step();
    s_data = 8'h44; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    checkOutput("pp_level_after", fifo_level, 2);
    checkOutput("pp_load_same_edge", signal_load, 1);
    checkOutput("pp_tx_data", tx_data, 8'h22);
    waitShifts("pp_drain_timeout", 40, 300);
    checkOutput("pp_loads", load_data.size(), 4);
    for (int f = 0; f < 4; f++)
      checkOutput($sformatf("pp_byte%0d", f), frameByte(f), 8'h11 * (f+1));

    // Busy falls early: sticky error, then a clean frame still goes out.
    repeat (5) step();
    clearLog();
    applyStimulus(8'hC3);
    waitShifts("fe_timeout", 3, 100);
    kill = 1'b1;
    step();
    step();
    checkOutput("fe_frame_err", frame_err, 1);
    checkOutput("fe_tx_idle", tx_idle, 1);
    kill = 1'b0;
    repeat (20) step();
    checkOutput("fe_no_more_shifts", bits.size(), 3);
    clearLog();
    applyStimulus(8'h3C);
    waitShifts("fe_next_timeout", 10, 100);
    got = '0;
    for (int k = 0; k < 10 && k < bits.size(); k++) got[k] = bits[k];
    checkOutput("fe_next_bits", got, 10'b1001111000);
    checkOutput("fe_sticky", frame_err, 1);

    // Reset mid-frame with three bytes still buffered.
    repeat (5) step();
    clearLog();
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    applyStimulus(8'hA3);
    applyStimulus(8'hA4);
    waitShifts("mr_timeout", 6, 100);
    checkOutput("mr_level_before", fifo_level, 3);
    RST = 1'b1;
    #1;
    checkOutput("mr_s_ready", s_ready, 1);
    checkOutput("mr_tx_data", tx_data, 0);
    checkOutput("mr_load", signal_load, 0);
    checkOutput("mr_shift", signal_shift, 0);
    checkOutput("mr_tx_idle", tx_idle, 1);
    checkOutput("mr_level", fifo_level, 0);
    checkOutput("mr_frame_err", frame_err, 0);
    repeat (3) step();
    RST = 1'b0;
    repeat (60) step();
    checkOutput("mr_no_shifts", bits.size(), 6);
    checkOutput("mr_no_loads", load_cyc.size(), 1);
    checkOutput("mr_line", line, 1);
    checkOutput("mr_idle_after", tx_idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
